// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Architectural register file at the consuming end of the writeback feedback
// path, with a per-register pending-write scoreboard for decode.
//
//   * One write port, fed by the registered writeback triple
//     (reg_data, reg_addr, reg_write). Writes to x0 are dropped.
//   * Two synchronous read ports with one cycle of latency. They advance only
//     while we=1 and otherwise hold. A writeback to the register being read in
//     the same cycle is forwarded straight to the read output.
//   * A saturating pending-write counter per register. Decode increments it on
//     issue (issue_valid/issue_rd) and writeback decrements it. rsN_busy
//     reports a source that still has an unresolved write in flight. The final
//     outstanding write landing in the same cycle is forwarded, so it does not
//     make the source busy.
//   * sb_overflow is sticky. It is set when an issue finds its counter already
//     saturated, and only reset clears it.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; overrides all other activity
//   we           read-port advance enable (0 = read outputs hold)
//   rs1_addr     read port 1 address     rs1_data  registered read data 1
//   rs2_addr     read port 2 address     rs2_data  registered read data 2
//   issue_valid  decode issues an instruction that writes issue_rd
//   issue_rd     destination register claimed at issue
//   reg_data     writeback data
//   reg_addr     writeback address
//   reg_write    writeback commit
//   rs1_busy     combinational: rs1 has an unresolved pending write
//   rs2_busy     combinational: rs2 has an unresolved pending write
//   hazard       combinational: rs1_busy | rs2_busy
//   sb_overflow  sticky: issue attempted on a saturated counter
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [DATA_W-1:0] reg_data,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic              reg_write,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              hazard,
    output logic              sb_overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem     [NREGS];
    logic [CNT_W-1:0]  cnt     [NREGS];
    logic [CNT_W-1:0]  cnt_nxt [NREGS];
    logic              overflow_set;

    // x0 and any address beyond the implemented register count are treated
    // alike: they read as zero, are never written and never pending.
    function automatic logic addr_real(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < NREGS);
    endfunction

    // -------------------------------------------------------------------------
    // Write port
    // -------------------------------------------------------------------------
    logic wr_en;
    assign wr_en = reg_write && addr_real(reg_addr);

    // -------------------------------------------------------------------------
    // Read-side lookups: next read data and pre-edge pending counts
    // -------------------------------------------------------------------------
    logic              wb_hit1, wb_hit2;
    logic [DATA_W-1:0] rd_next1, rd_next2;
    logic [CNT_W-1:0]  rs1_cnt, rs2_cnt;

    // NOTE: combinational blocks use blocking (=) assignments and give every
    // output a default first, so no path leaves a signal unassigned and no
    // latch is inferred. Clocked state below uses non-blocking (<=) only.
    always_comb begin
        wb_hit1  = reg_write && (reg_addr == rs1_addr);
        wb_hit2  = reg_write && (reg_addr == rs2_addr);
        rd_next1 = '0;
        rd_next2 = '0;
        rs1_cnt  = '0;
        rs2_cnt  = '0;

        if (addr_real(rs1_addr)) begin
            rs1_cnt  = cnt[rs1_addr];
            rd_next1 = wb_hit1 ? reg_data : mem[rs1_addr];
        end
        if (addr_real(rs2_addr)) begin
            rs2_cnt  = cnt[rs2_addr];
            rd_next2 = wb_hit2 ? reg_data : mem[rs2_addr];
        end
    end

    // -------------------------------------------------------------------------
    // Busy / hazard, evaluated on the pre-edge counts. A count of exactly one
    // that is being retired by this cycle's writeback is forwarded, so the
    // source is free. A same-cycle issue does not affect busy, which keeps an
    // instruction whose source equals its own rd from blocking itself.
    // -------------------------------------------------------------------------
    always_comb begin
        rs1_busy = (rs1_cnt != '0) && !(wb_hit1 && (rs1_cnt == CNT_ONE));
        rs2_busy = (rs2_cnt != '0) && !(wb_hit2 && (rs2_cnt == CNT_ONE));
        hazard   = rs1_busy || rs2_busy;
    end

    // -------------------------------------------------------------------------
    // Scoreboard next state
    // -------------------------------------------------------------------------
    logic [NREGS-1:0] inc_vec;
    logic [NREGS-1:0] dec_vec;

    always_comb begin
        inc_vec      = '0;
        dec_vec      = '0;
        overflow_set = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            cnt_nxt[r] = cnt[r];
        end

        // Entry 0 is never claimed, so cnt[0] stays at its reset value of 0.
        for (int r = 1; r < NREGS; r++) begin
            inc_vec[r] = issue_valid && (issue_rd == ADDR_W'(r));
            // An unclaimed writeback (count already 0) still writes the data
            // but must not wrap the counter.
            dec_vec[r] = reg_write && (reg_addr == ADDR_W'(r)) && (cnt[r] != '0);

            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt[r] == CNT_MAX) begin
                    overflow_set = 1'b1;
                end else begin
                    cnt_nxt[r] = cnt[r] + CNT_ONE;
                end
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_nxt[r] = cnt[r] - CNT_ONE;
            end
            // An issue and a retire of the same register in one cycle cancel
            // out, so the count is left unchanged.
        end
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register array is cleared by reset. Every entry has
            // to reach a known zero, and that costs a reset mux on each
            // storage bit, which rules out a plain RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
                cnt[i] <= '0;
            end
            rs1_data    <= '0;
            rs2_data    <= '0;
            sb_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[reg_addr] <= reg_data;
            end

            if (we) begin
                rs1_data <= rd_next1;
                rs2_data <= rd_next2;
            end

            for (int i = 0; i < NREGS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end

            if (overflow_set) begin
                sb_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Self-checking bench for regfile_scoreboard. A behavioural model (a plain
// register array, integer pending counts and a sticky flag) predicts every
// output. Combinational outputs are checked mid-cycle, before the edge.
// Registered outputs are checked 1 time unit after the edge. A directed walk
// through the key scenarios is followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] reg_data;
    logic [4:0]  reg_addr;
    logic        reg_write;
    logic        rs1_busy, rs2_busy, hazard, sb_overflow;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .reg_data    (reg_data),
        .reg_addr    (reg_addr),
        .reg_write   (reg_write),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .hazard      (hazard),
        .sb_overflow (sb_overflow)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_mem [32];
    int          m_cnt [32];
    bit          m_ovf;
    logic [31:0] m_rs1, m_rs2;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A source is pending while writes are outstanding, unless the last one
    // arrives in this very cycle.
    function automatic bit m_busy(input logic [4:0] a);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        if (reg_write && reg_addr == a && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (reg_write && reg_addr == a) return reg_data;
        return m_mem[a];
    endfunction

    // Apply the current (pre-edge) inputs to the model.
    task automatic model_update();
        bit inc, dec;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = 32'h0;
                m_cnt[i] = 0;
            end
            m_rs1 = 32'h0;
            m_rs2 = 32'h0;
            m_ovf = 1'b0;
            return;
        end
        if (we) begin
            m_rs1 = m_read(rs1_addr);
            m_rs2 = m_read(rs2_addr);
        end
        inc = issue_valid && issue_rd != 0;
        dec = reg_write && reg_addr != 0 && m_cnt[reg_addr] > 0;
        if (!(inc && dec && issue_rd == reg_addr)) begin
            if (inc) begin
                if (m_cnt[issue_rd] == 3) m_ovf = 1'b1;
                else m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
            end
            if (dec) m_cnt[reg_addr] = m_cnt[reg_addr] - 1;
        end
        if (reg_write && reg_addr != 0) m_mem[reg_addr] = reg_data;
    endtask

    // Mid-cycle: let inputs settle and check the combinational outputs.
    task automatic settle();
        #1;
        check("rs1_busy", 32'(rs1_busy), 32'(m_busy(rs1_addr)));
        check("rs2_busy", 32'(rs2_busy), 32'(m_busy(rs2_addr)));
        check("hazard", 32'(hazard), 32'(m_busy(rs1_addr) || m_busy(rs2_addr)));
    endtask

    // Clock edge: advance the model, then check the registered outputs.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("rs1_data", rs1_data, m_rs1);
        check("rs2_data", rs2_data, m_rs2);
        check("sb_overflow", 32'(sb_overflow), 32'(m_ovf));
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic idle();
        reset       = 1'b0;
        we          = 1'b0;
        rs1_addr    = 5'd0;
        rs2_addr    = 5'd0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        reg_write   = 1'b0;
        reg_addr    = 5'd0;
        reg_data    = 32'h0;
    endtask

    task automatic writeback(input logic [4:0] a, input logic [31:0] d);
        idle();
        reg_write = 1'b1;
        reg_addr  = a;
        reg_data  = d;
    endtask

    function automatic logic [4:0] pick();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'h0;
            m_cnt[i] = 0;
        end
        m_ovf = 1'b0;
        m_rs1 = 32'h0;
        m_rs2 = 32'h0;

        // Reset (state unknown before it, so only registered outputs are checked).
        idle();
        reset = 1'b1;
        tick();

        // Read x5 and x0 after reset.
        idle();
        rs1_addr = 5'd5; rs2_addr = 5'd0; we = 1'b1;
        cycle();
        check("reset_rs1", rs1_data, 32'h0);
        check("reset_rs2", rs2_data, 32'h0);
        check("reset_ovf", 32'(sb_overflow), 32'h0);

        // Plain write then read.
        writeback(5'd7, 32'hDEADBEEF);
        cycle();
        idle(); rs1_addr = 5'd7; we = 1'b1;
        cycle();
        check("read_x7", rs1_data, 32'hDEADBEEF);

        // Writes to x0 are dropped.
        writeback(5'd0, 32'h1234);
        cycle();
        idle(); rs1_addr = 5'd0; we = 1'b1;
        cycle();
        check("read_x0", rs1_data, 32'h0);

        // Same-cycle bypass, then hold when we=0.
        writeback(5'd3, 32'h11);
        cycle();
        writeback(5'd3, 32'hA5A5A5A5); rs2_addr = 5'd3; we = 1'b1;
        cycle();
        check("bypass_rs2", rs2_data, 32'hA5A5A5A5);
        writeback(5'd3, 32'h77); rs2_addr = 5'd3; we = 1'b0;
        cycle();
        check("stall_hold_rs2", rs2_data, 32'hA5A5A5A5);

        // Scoreboard claim and release of x9.
        idle(); issue_valid = 1'b1; issue_rd = 5'd9;
        cycle();
        idle(); rs1_addr = 5'd9; we = 1'b1;
        settle();
        check("x9_busy", 32'(rs1_busy), 32'h1);
        check("x9_hazard", 32'(hazard), 32'h1);
        tick();
        writeback(5'd9, 32'hCAFE0009); rs1_addr = 5'd9; we = 1'b1;
        settle();
        check("x9_release_busy", 32'(rs1_busy), 32'h0);
        tick();
        check("x9_bypass_data", rs1_data, 32'hCAFE0009);
        idle(); rs1_addr = 5'd9; we = 1'b1;
        settle();
        check("x9_cnt_zero", 32'(rs1_busy), 32'h0);
        tick();

        // Saturation and WAW on x4.
        for (int k = 0; k < 4; k++) begin
            idle(); issue_valid = 1'b1; issue_rd = 5'd4;
            cycle();
        end
        check("x4_overflow", 32'(sb_overflow), 32'h1);
        for (int k = 0; k < 2; k++) begin
            writeback(5'd4, 32'h40 + 32'(k)); rs1_addr = 5'd4; we = 1'b1;
            cycle();
        end
        idle(); rs1_addr = 5'd4; we = 1'b1;
        settle();
        check("x4_busy_cnt1", 32'(rs1_busy), 32'h1);
        tick();
        writeback(5'd4, 32'h44); issue_valid = 1'b1; issue_rd = 5'd4;
        cycle();
        idle(); rs1_addr = 5'd4; we = 1'b1;
        settle();
        check("x4_issue_wb_same", 32'(rs1_busy), 32'h1);
        tick();
        writeback(5'd4, 32'h45); rs1_addr = 5'd4; we = 1'b1;
        settle();
        check("x4_last_wb_busy", 32'(rs1_busy), 32'h0);
        tick();

        // Reset mid-flight on x12.
        idle(); issue_valid = 1'b1; issue_rd = 5'd12;
        cycle();
        idle(); reset = 1'b1; issue_valid = 1'b1; issue_rd = 5'd12;
        writeback(5'd12, 32'h99); reset = 1'b1;
        cycle();
        check("midflight_ovf_clr", 32'(sb_overflow), 32'h0);
        idle(); rs1_addr = 5'd12; we = 1'b1;
        settle();
        check("x12_not_busy", 32'(rs1_busy), 32'h0);
        tick();
        check("x12_reset_data", rs1_data, 32'h0);
        writeback(5'd12, 32'h55);
        cycle();
        idle(); rs1_addr = 5'd12; we = 1'b1;
        settle();
        check("x12_no_underflow", 32'(rs1_busy), 32'h0);
        tick();
        check("x12_data", rs1_data, 32'h55);

        // Randomized phase.
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 199) == 0);
            we          = ($urandom_range(0, 3) != 0);
            rs1_addr    = pick();
            rs2_addr    = ($urandom_range(0, 3) == 0) ? rs1_addr : pick();
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = pick();
            reg_write   = ($urandom_range(0, 1) == 1);
            reg_addr    = pick();
            reg_data    = $urandom;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Register file at the consuming end of the writeback feedback path. Accepts the registered writeback triple (data, address, write flag) driven by the WB stage.
- Serves two synchronous read ports to decode, with write-to-read bypass.
- Keeps a per-register pending-write scoreboard: decode claims a destination at issue, and writeback releases it. The scoreboard raises a hazard when a source register still has an in-flight write.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
NREGS, 32, number of architectural registers (x0 hardwired zero)
CNT_W, 2, width of per-register pending-write counter (max 2^CNT_W-1 in flight)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
we  in  1  read-port advance enable; 0 = read outputs hold (stall)
rs1_addr  in  ADDR_W  read port 1 address
rs2_addr  in  ADDR_W  read port 2 address
rs1_data  out  DATA_W  registered read data port 1
rs2_data  out  DATA_W  registered read data port 2
issue_valid  in  1  decode issues an instruction that writes issue_rd
issue_rd  in  ADDR_W  destination claimed at issue
reg_data  in  DATA_W  writeback data (from WB stage reg_data_out)
reg_addr  in  ADDR_W  writeback address (from WB stage reg_addr_out)
reg_write  in  1  writeback commit (from WB stage reg_write_out)
rs1_busy  out  1  combinational: rs1 has an unresolved pending write
rs2_busy  out  1  combinational: rs2 has an unresolved pending write
hazard  out  1  combinational: rs1_busy | rs2_busy
sb_overflow  out  1  sticky: issue attempted on a saturated counter

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - All registers, rs1_data, rs2_data and every pending counter go to 0.
  - sb_overflow goes to 0.
  - Reset overrides every simultaneous write, issue and read.
- Write port:
  - Condition: reg_write=1 and reg_addr!=0. Then mem[reg_addr] <= reg_data at the clock edge.
  - The write is not gated by we.
  - Writes to x0 are discarded.
- Read ports, 1-cycle latency, only when we=1. For port n:
  - rsn_data <= 0 if rsn_addr==0.
  - Otherwise rsn_data <= reg_data if reg_write=1 and reg_addr==rsn_addr (bypass).
  - Otherwise rsn_data <= mem[rsn_addr].
  - When we=0, rsn_data holds its value.
- Scoreboard, per register r != 0, counter cnt[r] of width CNT_W:
  - inc = issue_valid && issue_rd==r.
  - dec = reg_write && reg_addr==r && cnt[r]!=0.
  - inc and dec both set: cnt[r] is unchanged.
  - inc only: cnt[r]+1. If cnt[r] is already at max, cnt[r] holds and sb_overflow <= 1. sb_overflow is cleared only by reset.
  - dec only: cnt[r]-1.
  - Writeback with cnt[r]==0 (unclaimed, e.g. after reset mid-flight) still writes data; the counter stays 0.
  - issue_rd==0 is ignored; cnt[0] is constant 0.
- Busy (combinational, evaluated on pre-edge state):
  - rsn_busy = rsn_addr!=0 && cnt[rsn_addr]!=0 && !(reg_write && reg_addr==rsn_addr && cnt[rsn_addr]==1).
  - The final outstanding write arriving in the same cycle is bypassed, so the source is not busy.
- Issue in the same cycle as a read of the same register: busy reflects the pre-issue count. An instruction whose source equals its own rd is not self-blocked.
- rs1_addr==rs2_addr is legal; both ports return identical data and busy.

Test Plan:
- Reset, then read x5 and x0 with we=1:
  - Next cycle rs1_data=0, rs2_data=0.
  - Busy signals 0, sb_overflow=0.
- Writeback reg_addr=7, reg_data=0xDEADBEEF, reg_write=1; one cycle later read rs1=7 → rs1_data=0xDEADBEEF.
  - Writeback to x0 with 0x1234, then read x0 → 0.
- Same-cycle bypass:
  - Stimulus: reg_write=1, reg_addr=3, reg_data=0xA5A5A5A5, rs2_addr=3, we=1. x3 previously held 0x11.
  - Result: rs2_data=0xA5A5A5A5 next cycle.
  - Repeat with we=0 → rs2_data keeps its prior value.
- Scoreboard:
  - issue_valid with issue_rd=9, then rs1_addr=9 → rs1_busy=1, hazard=1.
  - Writeback to 9 with rs1_addr=9 in that cycle → rs1_busy=0 combinationally, and rs1_data=writeback value next cycle.
  - After that, cnt[9]=0.
- Saturation and WAW:
  - Issue rd=4 three times → cnt=3. A fourth issue sets sb_overflow=1 and cnt stays 3.
  - Two writebacks to 4 → rs1_busy still 1 (cnt=1).
  - Simultaneous issue and writeback of 4 → cnt unchanged.
- Reset mid-flight:
  - Issue rd=12, then assert reset → cnt[12]=0, sb_overflow=0.
  - A later writeback to 12 of 0x55 → data written (read returns 0x55), no counter underflow, busy stays 0.
